postage_stream_arbiter: RTL

- Round-robin, packet-atomic arbiter that shares the single postage-stamp stream input of the postage_maxi kernel between N_REQ upstream stamp producers.
- A grant is held from first beat to the TLAST beat; the output has one register stage.
- A stall watchdog counts cycles in which the kernel holds off the output. It raises a sticky stall flag for host/deadlock diagnostics.

---
 rtl/postage_stream_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/postage_stream_arbiter.sv
// Round-robin, packet-atomic arbiter feeding the postage_maxi stamp stream from N_REQ producers.
// One output register stage, with a sticky back-pressure watchdog for deadlock diagnostics.
module postage_stream_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 128,
    parameter int STALL_LIMIT = 1024,
    parameter int CNT_W       = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [N_REQ*DATA_W-1:0] s_tdata,
    input  logic [N_REQ-1:0]        s_tvalid,
    input  logic [N_REQ-1:0]        s_tlast,
    output logic [N_REQ-1:0]        s_tready,
    output logic [DATA_W-1:0]       m_tdata,
    output logic                    m_tvalid,
    output logic                    m_tlast,
    input  logic                    m_tready,
    output logic [N_REQ-1:0]        grant,
    output logic                    stall,
    input  logic                    stall_clear,
    output logic [CNT_W-1:0]        pkt_count
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(STALL_LIMIT + 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(STALL_LIMIT);
    localparam logic [WD_W-1:0]  WD_PRE   = WD_W'(STALL_LIMIT - 1);
    localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DAIN = 2'd2
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   g_idx;
    logic [WD_W-1:0]    wd_cnt;

    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   cand;
    logic [N_REQ-1:0]   pick_onehot;
    logic               pick_found;
    int                 scan;

    logic [DATA_W-1:0]  sel_data;
    logic               sel_valid;
    logic               sel_last;
    logic               out_room;
    logic               in_fire;
    logic               out_fire;

    // Scan from the requester after the last one served, wrapping modulo N_REQ.
    always_comb begin
        pick_found  = 1'b0;
        pick_idx    = '0;
        cand        = '0;
        scan        = 0;
        pick_onehot = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan = int'(ptr) + k;
            if (scan >= N_REQ) begin
                scan = scan - N_REQ;
            end
            cand = PTR_W'(scan);
            if (!pick_found && s_tvalid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
        pick_onehot[pick_idx] = 1'b1;
    end

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (g_idx == PTR_W'(i)) begin
                sel_data  = s_tdata[i*DATA_W +: DATA_W];
                sel_valid = s_tvalid[i];
                sel_last  = s_tlast[i];
            end
        end
    end

    assign out_room = ~m_tvalid | m_tready;
    assign in_fire  = (state == BUSY) & sel_valid & out_room;
    assign out_fire = m_tvalid & m_tready;
    assign s_tready = (state == BUSY) ? (grant & {N_REQ{out_room}}) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= PTR_INIT;
            g_idx     <= '0;
            grant     <= '0;
            m_tdata   <= '0;
            m_tvalid  <= 1'b0;
            m_tlast   <= 1'b0;
            pkt_count <= '0;
            wd_cnt    <= '0;
            stall     <= 1'b0;
        end else begin
            if (out_fire && m_tlast) begin
                pkt_count <= pkt_count + CNT_W'(1);
            end

            // A new load takes priority; it only happens when the register is free or draining.
            if (in_fire) begin
                m_tdata  <= sel_data;
                m_tlast  <= sel_last;
                m_tvalid <= 1'b1;
            end else if (out_fire) begin
                m_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (enable && pick_found) begin
                        grant <= pick_onehot;
                        g_idx <= pick_idx;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && sel_last) begin
                        grant <= '0;
                        ptr   <= g_idx;
                        state <= DAIN;
                    end
                end
                DAIN: begin
                    if (!m_tvalid || m_tready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (stall_clear || out_fire) begin
                wd_cnt <= '0;
            end else if (m_tvalid && wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end

            // Set on the edge that brings the count to the limit; clear always wins.
            if (stall_clear) begin
                stall <= 1'b0;
            end else if (m_tvalid && !m_tready && wd_cnt >= WD_PRE) begin
                stall <= 1'b1;
            end
        end
    end

endmodule
